systolic_a_ctrl: RTL and testbench

SYSTOLIC_A_CTRL -- requirements
Module: systolic_a_ctrl

---
 rtl/systolic_a_ctrl.sv | 66 ++++++
 tb/tb_systolic_a_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/systolic_a_ctrl.sv
// systolic_a_ctrl: loads DIM rows of the A tile into A memory, then runs the shift phase
module systolic_a_ctrl #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   hold,
    input  logic                                   row_valid,
    output logic                                   row_ready,
    input  logic signed [DIM-1:0][BITS_AB-1:0]     row_data,
    output logic signed [DIM-1:0][BITS_AB-1:0]     mem_Ain,
    output logic        [$clog2(DIM)-1:0]          mem_Arow,
    output logic                                   mem_WrEn,
    output logic                                   mem_en,
    output logic                                   busy,
    output logic                                   done
);
    localparam int AW = $clog2(DIM);
    localparam int RW = $clog2(3*DIM-1);
    localparam logic [AW-1:0] ROW_LAST = AW'(DIM-1);
    localparam logic [RW-1:0] RUN_LAST = RW'(3*DIM-3);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   row_cnt;
    logic [RW-1:0]   run_cnt;
    logic            hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        row_ready = state == LOAD && !abort;
        hs        = row_ready && row_valid;
        mem_WrEn  = hs;
        mem_Arow  = row_cnt;
        mem_Ain   = row_data;
        mem_en    = state == RUN && !hold && !abort;
        busy      = state != IDLE;
        done      = state == DONE && !abort;
        case (state)
            IDLE:    state_nxt = start && !abort ? LOAD : IDLE;
            LOAD:    state_nxt = abort ? IDLE : hs && row_cnt == ROW_LAST ? RUN : LOAD;
            RUN:     state_nxt = abort ? IDLE : mem_en && run_cnt == RUN_LAST ? DONE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // counters hold zero outside their own phase, so every entry starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            run_cnt <= '0;
        end else begin
            row_cnt <= state_nxt != LOAD ? '0 : hs ? row_cnt + AW'(1) : row_cnt;
            run_cnt <= state_nxt != RUN ? '0 : mem_en ? run_cnt + RW'(1) : run_cnt;
        end
    end
endmodule

// File: tb/tb_systolic_a_ctrl.sv
// tb_systolic_a_ctrl: directed checks of load, gapped load, hold, abort and reset for DIM=8
module tb_systolic_a_ctrl;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, hold = 0, row_valid = 0;
    logic [63:0] row_data = '0;
    logic [63:0] mem_Ain;
    logic [2:0]  mem_Arow;
    logic        row_ready, mem_WrEn, mem_en, busy, done;
    logic        done_q = 0;
    int          checks = 0, errors = 0, viol = 0;

    systolic_a_ctrl #(.BITS_AB(8), .DIM(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .mem_Ain(mem_Ain), .mem_Arow(mem_Arow), .mem_WrEn(mem_WrEn),
        .mem_en(mem_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_en && mem_WrEn) viol++;
        if (done && done_q) viol++;
        done_q = done;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] rv(input int i);
        logic [7:0] b;
        b = 8'(i*37 + 5);
        return {8{b}} ^ 64'h0f1e2d3c4b5a6978;
    endfunction

    task automatic begin_seq;
        start = 1;
        tick;
        start = 0;
    endtask

    task automatic load(input int n);
        row_valid = 1;
        for (int i = 0; i < n; i++) begin
            row_data = rv(i);
            #1;
            chk("ld_wr", 64'(mem_WrEn), 64'd1);
            chk("ld_row", 64'(mem_Arow), 64'(i));
            chk("ld_ain", mem_Ain, rv(i));
            tick;
        end
        row_valid = 0;
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, 64'({row_ready, mem_WrEn, mem_en, busy, done, mem_Arow}), 64'd0);
    endtask

    initial begin
        int r, en_n, nwr;
        logic v;
        #3;
        outs_zero("rst_outs");
        tick;
        rst_n = 1;
        tick;
        #1 outs_zero("idle_outs");

        begin_seq;
        #1 chk("nom_busy", 64'(busy), 64'd1);
        chk("nom_rdy", 64'(row_ready), 64'd1);
        load(8);
        for (int t = 0; t < 22; t++) begin
            #1 chk("nom_en", 64'({mem_en, done, row_ready}), 64'b100);
            tick;
        end
        start = 1;
        #1 chk("nom_done", 64'({done, mem_en, busy}), 64'b101);
        tick;
        start = 0;
        #1 chk("nom_idle", 64'({busy, done}), 64'd0);

        begin_seq;
        r = 0;
        nwr = 0;
        for (int t = 0; t < 11; t++) begin
            v = !(t >= 3 && t < 6);
            row_valid = v;
            row_data = rv(r);
            #1 chk("gap_rdy", 64'(row_ready), 64'd1);
            chk("gap_wr", 64'(mem_WrEn), 64'(v));
            chk("gap_row", 64'(mem_Arow), 64'(r));
            nwr += int'(mem_WrEn);
            tick;
            if (v) r++;
        end
        row_valid = 0;
        chk("gap_nwr", 64'(nwr), 64'd8);
        en_n = 0;
        for (int t = 0; t < 27; t++) begin
            hold = t >= 10 && t < 15;
            #1 chk("hold_en", 64'(mem_en), 64'(!hold));
            chk("hold_nodone", 64'(done), 64'd0);
            en_n += int'(mem_en);
            tick;
        end
        hold = 0;
        #1 chk("hold_done", 64'(done), 64'd1);
        chk("hold_total", 64'(en_n), 64'd22);
        tick;
        #1 chk("hold_idle", 64'(busy), 64'd0);

        start = 1;
        abort = 1;
        tick;
        start = 0;
        abort = 0;
        #1 chk("idle_abort", 64'(busy), 64'd0);

        begin_seq;
        row_valid = 1;
        abort = 1;
        #1 chk("ldab_out", 64'({row_ready, mem_WrEn}), 64'd0);
        tick;
        abort = 0;
        row_valid = 0;
        #1 chk("ldab_idle", 64'(busy), 64'd0);

        begin_seq;
        load(8);
        start = 1;
        for (int t = 0; t < 4; t++) begin
            #1 chk("rab_en", 64'(mem_en), 64'd1);
            tick;
        end
        abort = 1;
        #1 chk("rab_out", 64'({mem_en, mem_WrEn, row_ready, done}), 64'd0);
        tick;
        abort = 0;
        start = 0;
        for (int t = 0; t < 3; t++) begin
            #1 chk("rab_idle", 64'({busy, done}), 64'd0);
            tick;
        end

        begin_seq;
        load(5);
        row_valid = 1;
        row_data = rv(5);
        #1 chk("rst_row5", 64'(mem_Arow), 64'd5);
        rst_n = 0;
        #1 outs_zero("rst_mid");
        tick;
        rst_n = 1;
        row_valid = 0;
        tick;
        #1 chk("rst_stay", 64'(busy), 64'd0);
        tick;
        begin_seq;
        row_valid = 1;
        row_data = rv(0);
        #1 chk("rst_reload", 64'({mem_WrEn, mem_Arow}), 64'b1000);
        tick;
        row_valid = 0;

        chk("excl_width", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
